// File: rtl/seq_divider64.sv
// Multi-cycle restoring divider producing one quotient bit per clock, with valid/ready on both sides.
// Define SIGNED_DIV_EN to honour is_signed (magnitude conversion, FIX state, overflow flag).
module seq_divider64 #(
    parameter int N     = 64,
    parameter int CNT_W = 7
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         is_signed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         dbz_flag,
    output logic         of_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
`ifdef SIGNED_DIV_EN
        FIX  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [N-1:0]     q_reg;
    logic [N-1:0]     r_reg;
    logic [N-1:0]     d_reg;
    logic [CNT_W-1:0] count;
    logic             dbz_reg;

    logic             accept;
    logic [N-1:0]     a_mag;
    logic [N-1:0]     b_mag;
    logic [N-1:0]     dbz_quotient;
    logic             overflow;
    logic [N:0]       shifted_r;
    logic [N:0]       trial;

    assign accept = in_valid && in_ready;

`ifdef SIGNED_DIV_EN
    logic a_neg;
    logic b_neg;
    logic signed_op;
    logic neg_q;
    logic neg_r;
    logic of_reg;

    // Operands become magnitudes at accept; the most negative value maps to 2^(N-1) unsigned.
    assign a_neg        = is_signed && dividend[N-1];
    assign b_neg        = is_signed && divisor[N-1];
    assign a_mag        = a_neg ? -dividend : dividend;
    assign b_mag        = b_neg ? -divisor : divisor;
    assign dbz_quotient = is_signed ? '0 : '1;
    assign overflow     = is_signed && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign a_mag            = dividend;
    assign b_mag            = divisor;
    assign dbz_quotient     = '1;
    assign overflow         = 1'b0;
`endif

    // The top bit of the (N+1)-bit trial subtract is the borrow: set means the divisor did not fit.
    assign shifted_r = {r_reg, q_reg[N-1]};
    assign trial     = shifted_r - {1'b0, d_reg};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == CNT_W'(1)) begin
`ifdef SIGNED_DIV_EN
                    next_state = signed_op ? FIX : DONE;
`else
                    next_state = DONE;
`endif
                end
            end
`ifdef SIGNED_DIV_EN
            FIX: begin
                next_state = DONE;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        quotient  = q_reg;
        remainder = r_reg;
        dbz_flag  = dbz_reg;
`ifdef SIGNED_DIV_EN
        of_flag   = of_reg;
`else
        of_flag   = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_reg   <= '0;
            r_reg   <= '0;
            d_reg   <= '0;
            count   <= '0;
            dbz_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        count   <= CNT_W'(N);
                        d_reg   <= b_mag;
                        dbz_reg <= (divisor == '0);
                        if (divisor == '0) begin
                            q_reg <= dbz_quotient;
                            r_reg <= dividend;
                        end else begin
                            q_reg <= a_mag;
                            r_reg <= '0;
                        end
                    end
                end
                CALC: begin
                    count <= count - CNT_W'(1);
                    if (!trial[N]) begin
                        r_reg <= trial[N-1:0];
                        q_reg <= {q_reg[N-2:0], 1'b1};
                    end else begin
                        r_reg <= shifted_r[N-1:0];
                        q_reg <= {q_reg[N-2:0], 1'b0};
                    end
                end
`ifdef SIGNED_DIV_EN
                FIX: begin
                    if (neg_q) begin
                        q_reg <= -q_reg;
                    end
                    if (neg_r) begin
                        r_reg <= -r_reg;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifdef SIGNED_DIV_EN
    // Sign corrections are decided from the raw operands at accept, since inputs may change afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            signed_op <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            of_reg    <= 1'b0;
        end else if (accept) begin
            signed_op <= is_signed;
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
            of_reg    <= overflow;
        end
    end
`endif

endmodule
